// File: rtl/dijkstra_edge_reader.sv
// dijkstra_edge_reader: variable-latency custom instruction that walks one
// adjacency-list row through an Avalon-MM pipelined read master and returns
// the edge word {node_id, weight} with the smallest weight.
// Optional build macro: DIJKSTRA_EDGE_SKIP_VISITED_EN -- when defined, entries
// whose node_id bit 15 (readdata[31]) is set are counted but never selected.
module dijkstra_edge_reader #(
    parameter int ADDR_W      = 32,
    parameter int MAX_PENDING = 4,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       dataa,
    input  logic [31:0]       datab,
    output logic              done,
    output logic [31:0]       result,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    // Wide enough for MAX_PENDING up to 15.
    localparam int PEND_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [CNT_W-1:0]   n_reg, n_next;
    logic [CNT_W-1:0]   issued_reg, issued_next;
    logic [CNT_W-1:0]   received_reg, received_next;
    logic [PEND_W-1:0]  pending_reg, pending_next;
    logic [31:0]        best_reg, best_next;
    logic [31:0]        result_reg, result_next;

    logic               accept;
    logic               rsp;
    logic               better;
    logic               unused_bits;

    // Address low bits and upper count bits carry no meaning here.
    assign unused_bits = ^{dataa[1:0], datab};

    // Request is a pure function of registered state, so it cannot change
    // while the slave holds waitrequest (pending can only fall meanwhile).
    assign avm_read    = (state_reg == ISSUE) && (issued_reg < n_reg) &&
                         (pending_reg < PEND_W'(MAX_PENDING));
    assign avm_address = addr_reg;
    assign accept      = avm_read && !avm_waitrequest;
    assign rsp         = avm_readdatavalid &&
                         ((state_reg == ISSUE) || (state_reg == DRAIN));

`ifdef DIJKSTRA_EDGE_SKIP_VISITED_EN
    // Visited nodes still count as received but never win.
    assign better = (avm_readdata[15:0] < best_reg[15:0]) && !avm_readdata[31];
`else
    assign better = (avm_readdata[15:0] < best_reg[15:0]);
`endif

    // Result is presented combinationally during the DONE cycle and held after.
    assign done   = (state_reg == DONE);
    assign result = done ? best_reg : result_reg;

    // Next-state and datapath updates; strict '<' keeps the first of equal weights.
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        n_next        = n_reg;
        issued_next   = issued_reg;
        received_next = received_reg;
        pending_next  = pending_reg;
        best_next     = best_reg;
        result_next   = result_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    addr_next     = ADDR_W'({dataa[31:2], 2'b00});
                    n_next        = datab[CNT_W-1:0];
                    best_next     = 32'hFFFF_FFFF;
                    issued_next   = '0;
                    received_next = '0;
                    pending_next  = '0;
                    state_next    = (datab[CNT_W-1:0] == '0) ? DONE : ISSUE;
                end
            end
            ISSUE, DRAIN: begin
                if (accept) begin
                    issued_next = issued_reg + 1'b1;
                    addr_next   = addr_reg + ADDR_W'(4);
                end
                case ({accept, rsp})
                    2'b10:   pending_next = pending_reg + 1'b1;
                    2'b01:   pending_next = pending_reg - 1'b1;
                    default: pending_next = pending_reg;
                endcase
                if (rsp) begin
                    received_next = received_reg + 1'b1;
                    if (better) begin
                        best_next = avm_readdata;
                    end
                end
                // Look at the post-update counters so done follows the last beat by one cycle.
                if (received_next == n_reg) begin
                    state_next = DONE;
                end else if ((state_reg == ISSUE) && (issued_next == n_reg)) begin
                    state_next = DRAIN;
                end
            end
            DONE: begin
                result_next = best_reg;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            n_reg        <= '0;
            issued_reg   <= '0;
            received_reg <= '0;
            pending_reg  <= '0;
            best_reg     <= 32'hFFFF_FFFF;
            result_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            n_reg        <= n_next;
            issued_reg   <= issued_next;
            received_reg <= received_next;
            pending_reg  <= pending_next;
            best_reg     <= best_next;
            result_reg   <= result_next;
        end
    end

endmodule
